// File: rtl/ctrl_seq_if.sv
// Instruction, RAM, writeback and status bundle for ctrl_seq.
// master = sequencer side, slave = fetch/datapath side.
interface ctrl_seq_if #(
   parameter int DW = 32,
   parameter int RW = 5,
   parameter int IW = 16
);
   logic          i_run;
   logic          i_ir_valid;
   logic          o_ir_ready;
   logic [IW-1:0] i_ir;
   logic [3:0]    i_inst;
   logic [RW-1:0] i_reg0;
   logic [RW-1:0] i_reg1;
   logic [DW-1:0] i_val_reg0;
   logic [DW-1:0] i_val_reg1;
   logic [DW-1:0] i_pc_inc;
   logic [3:0]    o_alu_action;
   logic          o_ram_req;
   logic [1:0]    o_ram_action;
   logic [DW-1:0] o_ram_addr;
   logic          i_ram_ack;
   logic          o_wb_en;
   logic [RW-1:0] o_wb_reg;
   logic [1:0]    o_wb_type;
   logic          o_do_jump;
   logic [DW-1:0] o_pc_jump;
   logic          o_run;
   logic          o_fault;
   logic [2:0]    o_state;

   modport master (
      input  i_run, i_ir_valid, i_ir, i_inst,
      input  i_reg0, i_reg1, i_val_reg0, i_val_reg1,
      input  i_pc_inc, i_ram_ack,
      output o_ir_ready, o_alu_action, o_ram_req,
      output o_ram_action, o_ram_addr, o_wb_en,
      output o_wb_reg, o_wb_type, o_do_jump,
      output o_pc_jump, o_run, o_fault, o_state
   );

   modport slave (
      output i_run, i_ir_valid, i_ir, i_inst,
      output i_reg0, i_reg1, i_val_reg0, i_val_reg1,
      output i_pc_inc, i_ram_ack,
      input  o_ir_ready, o_alu_action, o_ram_req,
      input  o_ram_action, o_ram_addr, o_wb_en,
      input  o_wb_reg, o_wb_type, o_do_jump,
      input  o_pc_jump, o_run, o_fault, o_state
   );
endinterface

// File: rtl/ctrl_seq.sv
// Shared encodings plus the multi-cycle control sequencer:
// IDLE -> EXEC -> (MEM) -> WB, with sticky HALT and FAULT.
package ctrl_seq_pkg;
   localparam logic [3:0] OP_MOV  = 4'd0;
   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_SUB  = 4'd2;
   localparam logic [3:0] OP_ASR  = 4'd3;
   localparam logic [3:0] OP_ASL  = 4'd4;
   localparam logic [3:0] OP_OR   = 4'd5;
   localparam logic [3:0] OP_AND  = 4'd6;
   localparam logic [3:0] OP_XOR  = 4'd7;
   localparam logic [3:0] OP_LSL  = 4'd8;
   localparam logic [3:0] OP_LSR  = 4'd9;
   localparam logic [3:0] OP_CND  = 4'd10;
   localparam logic [3:0] OP_SPEC = 4'd11;
   localparam logic [3:0] OP_LD   = 4'd12;
   localparam logic [3:0] OP_LDA  = 4'd13;
   localparam logic [3:0] OP_ST   = 4'd14;
   localparam logic [3:0] OP_CBR  = 4'd15;

   localparam logic [3:0] ALU_NOP = 4'd0;
   localparam logic [3:0] ALU_MOV = 4'd1;
   localparam logic [3:0] ALU_ADD = 4'd2;
   localparam logic [3:0] ALU_SUB = 4'd3;
   localparam logic [3:0] ALU_ASR = 4'd4;
   localparam logic [3:0] ALU_ASL = 4'd5;
   localparam logic [3:0] ALU_OR  = 4'd6;
   localparam logic [3:0] ALU_AND = 4'd7;
   localparam logic [3:0] ALU_XOR = 4'd8;
   localparam logic [3:0] ALU_LSL = 4'd9;
   localparam logic [3:0] ALU_LSR = 4'd10;
   localparam logic [3:0] ALU_CND = 4'd11;

   localparam logic [1:0] RAM_NONE  = 2'd0;
   localparam logic [1:0] RAM_READ  = 2'd1;
   localparam logic [1:0] RAM_WRITE = 2'd2;

   localparam logic [1:0] WB_NONE = 2'd0;
   localparam logic [1:0] WB_ALU  = 2'd1;
   localparam logic [1:0] WB_RAM  = 2'd2;
   localparam logic [1:0] WB_PC   = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_EXEC  = 3'd1,
      S_MEM   = 3'd2,
      S_WB    = 3'd3,
      S_HALT  = 3'd4,
      S_FAULT = 3'd5
   } state_t;
endpackage

module ctrl_seq
   import ctrl_seq_pkg::*;
#(
   parameter int DW      = 32,
   parameter int RW      = 5,
   parameter int IW      = 16,
   parameter int PC_STEP = 4,
   parameter int TIMEOUT = 16
) (
   input logic         i_clk,
   input logic         i_rst,
   ctrl_seq_if.master  bus
);
   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   state_t        state;
   logic [CW-1:0] cnt;
   logic [3:0]    op_q;
   logic [RW-1:0] reg0_q, reg1_q;
   logic [DW-1:0] v0_q, v1_q, pc_q;

   logic [3:0]    alu_q;
   logic          req_q;
   logic [1:0]    ract_q;
   logic [DW-1:0] raddr_q;
   logic          wb_en_q;
   logic [RW-1:0] wb_reg_q;
   logic [1:0]    wb_type_q;
   logic          jump_q;
   logic [DW-1:0] pcj_q;
   logic          fault_q;

   logic          is_ld, is_lda, is_st, is_cbr, is_mem;
   logic [3:0]    alu_sel;
   logic [1:0]    wb_sel;
   logic [RW-1:0] wbreg_sel;
   logic          jump_sel;
   logic [DW-1:0] pcj_sel;
   logic [DW-1:0] raddr_sel;
   logic          run_ok, ready;

   always_comb begin
      is_ld  = (op_q == OP_LD);
      is_lda = (op_q == OP_LDA);
      is_st  = (op_q == OP_ST);
      is_cbr = (op_q == OP_CBR);
      is_mem = is_ld | is_lda | is_st;
      case (op_q)
         OP_MOV:  alu_sel = ALU_MOV;
         OP_ADD:  alu_sel = ALU_ADD;
         OP_SUB:  alu_sel = ALU_SUB;
         OP_ASR:  alu_sel = ALU_ASR;
         OP_ASL:  alu_sel = ALU_ASL;
         OP_OR:   alu_sel = ALU_OR;
         OP_AND:  alu_sel = ALU_AND;
         OP_XOR:  alu_sel = ALU_XOR;
         OP_LSL:  alu_sel = ALU_LSL;
         OP_LSR:  alu_sel = ALU_LSR;
         OP_CND:  alu_sel = ALU_CND;
         default: alu_sel = ALU_NOP;
      endcase
      // Loads and branches take precedence over the NOP -> no-writeback rule
      if (is_ld || is_lda)         wb_sel = WB_RAM;
      else if (is_cbr)             wb_sel = WB_PC;
      else if (alu_sel == ALU_NOP) wb_sel = WB_NONE;
      else                         wb_sel = WB_ALU;
      wbreg_sel = is_cbr ? reg0_q : reg1_q;
      jump_sel  = (is_cbr && v0_q != '0) || is_lda;
      pcj_sel   = is_lda ? (pc_q + DW'(PC_STEP)) : v1_q;
      unique case (1'b1)
         is_ld:   raddr_sel = v0_q;
         is_lda:  raddr_sel = pc_q;
         default: raddr_sel = v1_q;
      endcase
   end

   assign run_ok = bus.i_run & ~i_rst;
   assign ready  = (state == S_IDLE) & run_ok;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         op_q      <= '0;
         reg0_q    <= '0;
         reg1_q    <= '0;
         v0_q      <= '0;
         v1_q      <= '0;
         pc_q      <= '0;
         alu_q     <= '0;
         req_q     <= 1'b0;
         ract_q    <= RAM_NONE;
         raddr_q   <= '0;
         wb_en_q   <= 1'b0;
         wb_reg_q  <= '0;
         wb_type_q <= WB_NONE;
         jump_q    <= 1'b0;
         pcj_q     <= '0;
         fault_q   <= 1'b0;
      end else begin
         wb_en_q <= 1'b0;
         jump_q  <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (bus.i_ir_valid && ready) begin
                  op_q   <= bus.i_inst;
                  reg0_q <= bus.i_reg0;
                  reg1_q <= bus.i_reg1;
                  v0_q   <= bus.i_val_reg0;
                  v1_q   <= bus.i_val_reg1;
                  pc_q   <= bus.i_pc_inc;
                  state  <= (bus.i_ir == '0) ? S_HALT : S_EXEC;
               end
            end
            S_EXEC: begin
               if (is_mem) begin
                  state   <= S_MEM;
                  cnt     <= '0;
                  req_q   <= 1'b1;
                  ract_q  <= is_st ? RAM_WRITE : RAM_READ;
                  raddr_q <= raddr_sel;
               end else begin
                  state     <= S_WB;
                  alu_q     <= alu_sel;
                  wb_type_q <= wb_sel;
                  wb_reg_q  <= wbreg_sel;
                  wb_en_q   <= (wb_sel != WB_NONE);
                  jump_q    <= jump_sel;
                  pcj_q     <= pcj_sel;
               end
            end
            S_MEM: begin
               // Ack is checked first so it wins over a same-cycle timeout
               if (bus.i_ram_ack) begin
                  req_q  <= 1'b0;
                  ract_q <= RAM_NONE;
                  if (is_st) begin
                     state <= S_IDLE;
                  end else begin
                     state     <= S_WB;
                     alu_q     <= alu_sel;
                     wb_type_q <= wb_sel;
                     wb_reg_q  <= wbreg_sel;
                     wb_en_q   <= (wb_sel != WB_NONE);
                     jump_q    <= jump_sel;
                     pcj_q     <= pcj_sel;
                  end
               end else if (cnt == CNT_LAST) begin
                  state   <= S_FAULT;
                  req_q   <= 1'b0;
                  ract_q  <= RAM_NONE;
                  fault_q <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_WB:    state <= S_IDLE;
            S_HALT:  state <= S_HALT;
            S_FAULT: state <= S_FAULT;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.o_ir_ready   = ready;
   assign bus.o_alu_action = alu_q;
   assign bus.o_ram_req    = req_q;
   assign bus.o_ram_action = ract_q;
   assign bus.o_ram_addr   = raddr_q;
   assign bus.o_wb_en      = wb_en_q;
   assign bus.o_wb_reg     = wb_reg_q;
   assign bus.o_wb_type    = wb_type_q;
   assign bus.o_do_jump    = jump_q;
   assign bus.o_pc_jump    = pcj_q;
   assign bus.o_fault      = fault_q;
   assign bus.o_state      = state;
   assign bus.o_run        = (state == S_IDLE) ? run_ok :
                             (state == S_EXEC) || (state == S_MEM) ||
                             (state == S_WB);
endmodule

// File: tb/tb_ctrl_seq.sv
// Directed bench for ctrl_seq: ALU, load, branch, LDA wrap,
// store timeout/ack race, halt and reset behaviour.
module tb_ctrl_seq;
   import ctrl_seq_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   ncmp = 0;
   int   nerr = 0;

   always #5 clk = ~clk;

   ctrl_seq_if #(.DW(32), .RW(5), .IW(16)) bus ();

   ctrl_seq #(
      .DW(32), .RW(5), .IW(16), .PC_STEP(4), .TIMEOUT(16)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus.master)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic issue(input logic [3:0] op, input logic [4:0] r0,
                        input logic [4:0] r1, input logic [31:0] v0,
                        input logic [31:0] v1, input logic [31:0] pc,
                        input logic [15:0] ir);
      bus.i_inst     = op;
      bus.i_reg0     = r0;
      bus.i_reg1     = r1;
      bus.i_val_reg0 = v0;
      bus.i_val_reg1 = v1;
      bus.i_pc_inc   = pc;
      bus.i_ir       = ir;
      bus.i_ir_valid = 1'b1;
      step(1);
      bus.i_ir_valid = 1'b0;
   endtask

   initial begin
      rst            = 1'b1;
      bus.i_run      = 1'b0;
      bus.i_ir_valid = 1'b0;
      bus.i_ir       = '0;
      bus.i_inst     = '0;
      bus.i_reg0     = '0;
      bus.i_reg1     = '0;
      bus.i_val_reg0 = '0;
      bus.i_val_reg1 = '0;
      bus.i_pc_inc   = '0;
      bus.i_ram_ack  = 1'b0;
      step(2);
      chk("rst_state", bus.o_state, 0);
      chk("rst_run", bus.o_run, 0);
      chk("rst_ready", bus.o_ir_ready, 0);
      chk("rst_fault", bus.o_fault, 0);
      chk("rst_req", bus.o_ram_req, 0);
      chk("rst_wb_en", bus.o_wb_en, 0);
      rst       = 1'b0;
      bus.i_run = 1'b1;
      #1;
      chk("idle_ready", bus.o_ir_ready, 1);
      chk("idle_run", bus.o_run, 1);
      step(1);

      // ADD: EXEC, then WB strobe, then ready again
      issue(OP_ADD, 5'd1, 5'd3, 32'h11, 32'h22, 32'h0, 16'h1234);
      chk("add_exec", bus.o_state, 1);
      chk("add_exec_rdy", bus.o_ir_ready, 0);
      step(1);
      chk("add_wb_en", bus.o_wb_en, 1);
      chk("add_wb_type", bus.o_wb_type, WB_ALU);
      chk("add_alu", bus.o_alu_action, ALU_ADD);
      chk("add_wb_reg", bus.o_wb_reg, 3);
      chk("add_jump", bus.o_do_jump, 0);
      step(1);
      chk("add_wb_pulse", bus.o_wb_en, 0);
      chk("add_ready", bus.o_ir_ready, 1);

      // LD with ack after three request cycles
      issue(OP_LD, 5'd2, 5'd7, 32'h100, 32'h0, 32'h0, 16'h0c27);
      step(1);
      chk("ld_req", bus.o_ram_req, 1);
      chk("ld_addr", bus.o_ram_addr, 32'h100);
      chk("ld_act", bus.o_ram_action, RAM_READ);
      step(1);
      chk("ld_addr_hold", bus.o_ram_addr, 32'h100);
      step(1);
      bus.i_ram_ack = 1'b1;
      step(1);
      bus.i_ram_ack = 1'b0;
      chk("ld_wb_state", bus.o_state, 3);
      chk("ld_wb_en", bus.o_wb_en, 1);
      chk("ld_wb_type", bus.o_wb_type, WB_RAM);
      chk("ld_wb_reg", bus.o_wb_reg, 7);
      chk("ld_req_drop", bus.o_ram_req, 0);
      chk("ld_alu_nop", bus.o_alu_action, ALU_NOP);
      step(1);

      // CBR taken and not taken
      issue(OP_CBR, 5'd5, 5'd6, 32'h1, 32'h40, 32'h0, 16'hf560);
      step(1);
      chk("cbr_jump", bus.o_do_jump, 1);
      chk("cbr_target", bus.o_pc_jump, 32'h40);
      chk("cbr_type", bus.o_wb_type, WB_PC);
      chk("cbr_reg", bus.o_wb_reg, 5);
      chk("cbr_wb_en", bus.o_wb_en, 1);
      step(1);
      chk("cbr_pulse", bus.o_do_jump, 0);
      issue(OP_CBR, 5'd4, 5'd6, 32'h0, 32'h80, 32'h0, 16'hf460);
      step(1);
      chk("cbr_nt_jump", bus.o_do_jump, 0);
      chk("cbr_nt_type", bus.o_wb_type, WB_PC);
      step(1);

      // LDA: read at pc_inc, jump target wraps
      issue(OP_LDA, 5'd0, 5'd9, 32'h0, 32'h0, 32'hFFFF_FFFE, 16'hd090);
      step(1);
      chk("lda_addr", bus.o_ram_addr, 32'hFFFF_FFFE);
      chk("lda_act", bus.o_ram_action, RAM_READ);
      bus.i_ram_ack = 1'b1;
      step(1);
      bus.i_ram_ack = 1'b0;
      chk("lda_jump", bus.o_do_jump, 1);
      chk("lda_target", bus.o_pc_jump, 32'h2);
      chk("lda_type", bus.o_wb_type, WB_RAM);
      chk("lda_reg", bus.o_wb_reg, 9);
      step(1);

      // ST with ack in the 16th MEM cycle: ack beats timeout
      issue(OP_ST, 5'd1, 5'd2, 32'h0, 32'h200, 32'h0, 16'he120);
      step(1);
      chk("st_act", bus.o_ram_action, RAM_WRITE);
      chk("st_addr", bus.o_ram_addr, 32'h200);
      step(15);
      chk("st_race_mem", bus.o_state, 2);
      bus.i_ram_ack = 1'b1;
      step(1);
      bus.i_ram_ack = 1'b0;
      chk("st_race_idle", bus.o_state, 0);
      chk("st_race_fault", bus.o_fault, 0);
      chk("st_race_rdy", bus.o_ir_ready, 1);

      // ST never acked: fault after 16 MEM cycles
      issue(OP_ST, 5'd1, 5'd2, 32'h0, 32'h300, 32'h0, 16'he120);
      step(1);
      step(15);
      chk("st_to_mem16", bus.o_state, 2);
      chk("st_to_req16", bus.o_ram_req, 1);
      step(1);
      chk("fault_state", bus.o_state, 5);
      chk("fault_flag", bus.o_fault, 1);
      chk("fault_run", bus.o_run, 0);
      chk("fault_req", bus.o_ram_req, 0);
      step(2);
      chk("fault_sticky", bus.o_fault, 1);
      rst = 1'b1;
      step(1);
      chk("rst2_state", bus.o_state, 0);
      chk("rst2_fault", bus.o_fault, 0);
      chk("rst2_run", bus.o_run, 0);
      chk("rst2_ready", bus.o_ir_ready, 0);
      chk("rst2_pcj", bus.o_pc_jump, 0);
      chk("rst2_addr", bus.o_ram_addr, 0);
      chk("rst2_alu", bus.o_alu_action, 0);
      rst = 1'b0;
      step(1);

      // i_run dropped mid-instruction
      issue(OP_XOR, 5'd1, 5'd8, 32'h0, 32'h0, 32'h0, 16'h7180);
      bus.i_run = 1'b0;
      step(1);
      chk("drop_wb_en", bus.o_wb_en, 1);
      chk("drop_alu", bus.o_alu_action, ALU_XOR);
      chk("drop_run_wb", bus.o_run, 1);
      step(1);
      chk("drop_idle_rdy", bus.o_ir_ready, 0);
      chk("drop_idle_run", bus.o_run, 0);
      bus.i_run = 1'b1;
      step(1);

      // Halt on all-zero instruction word
      issue(OP_ADD, 5'd1, 5'd2, 32'h0, 32'h0, 32'h0, 16'h0000);
      chk("halt_state", bus.o_state, 4);
      chk("halt_run", bus.o_run, 0);
      chk("halt_ready", bus.o_ir_ready, 0);
      bus.i_ir_valid = 1'b1;
      bus.i_ir       = 16'h1234;
      step(3);
      bus.i_ir_valid = 1'b0;
      chk("halt_hold", bus.o_state, 4);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      chk("halt_rst", bus.o_state, 0);

      // Reset mid-MEM
      issue(OP_LD, 5'd1, 5'd2, 32'h300, 32'h0, 32'h0, 16'hc120);
      step(1);
      chk("mid_req", bus.o_ram_req, 1);
      rst = 1'b1;
      step(1);
      chk("mid_req_drop", bus.o_ram_req, 0);
      chk("mid_state", bus.o_state, 0);
      rst = 1'b0;
      step(1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end
endmodule
